// File: rtl/pipe_execute.sv
// Execute stage: single-cycle ALU plus iterative shift-add multiply and restoring
// divide (one bit per cycle), with valid/ready handshakes on input and output.
module pipe_execute #(
  parameter int XLEN = 32,
  parameter int OP_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            alub_sel_i,
  input  logic [OP_W-1:0] alu_op_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] rD2_i,
  input  logic [XLEN-1:0] ext_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] C_o,
  output logic            eq_o,
  output logic            lt_o,
  output logic            ltu_o
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(10);

  typedef enum logic { IDLE, BUSY } state_e;
  typedef enum logic [1:0] { IT_MUL, IT_DIVU, IT_REMU } iter_e;

  state_e           state_q;
  iter_e            iter_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  wa_q, wb_q, acc_q;
  logic [XLEN-1:0]  wa_d, wb_d, acc_d;
  logic             peq_q, plt_q, pltu_q;
  logic [XLEN-1:0]  c_q;
  logic             eq_q, lt_q, ltu_q, valid_q;

  logic [XLEN-1:0]  b_op, alu_res, iter_res;
  logic [SH_W-1:0]  shamt;
  logic             eq_in, lt_in, ltu_in, is_iter;
  iter_e            iter_in;
  logic [XLEN:0]    rem_sh, rem_diff;
  logic             accept, last_iter;

  // Gated by reset so the block never advertises readiness while held in reset.
  assign in_ready_o = !rst_i && (state_q == IDLE) && (!valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign last_iter  = (cnt_q == CNT_W'(1));

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    b_op    = alub_sel_i ? ext_i : rD2_i;
    shamt   = b_op[SH_W-1:0];
    eq_in   = (A_i == b_op);
    lt_in   = ($signed(A_i) < $signed(b_op));
    ltu_in  = (A_i < b_op);
    alu_res = '0;
    is_iter = 1'b0;
    iter_in = IT_MUL;
    case (alu_op_i)
      OP_ADD:  alu_res = A_i + b_op;
      OP_SUB:  alu_res = A_i - b_op;
      OP_AND:  alu_res = A_i & b_op;
      OP_OR:   alu_res = A_i | b_op;
      OP_XOR:  alu_res = A_i ^ b_op;
      OP_SLL:  alu_res = A_i << shamt;
      OP_SRL:  alu_res = A_i >> shamt;
      OP_SRA:  alu_res = $signed(A_i) >>> shamt;
      OP_MUL:  begin is_iter = 1'b1; iter_in = IT_MUL;  end
      OP_DIVU: begin is_iter = 1'b1; iter_in = IT_DIVU; end
      OP_REMU: begin is_iter = 1'b1; iter_in = IT_REMU; end
      default: alu_res = '0;
    endcase
  end

  // MUL: wa = shifted multiplicand, wb = multiplier, acc = product.
  // DIV: wa = divisor, wb = dividend shifting into quotient, acc = remainder.
  // A zero divisor naturally yields all-ones quotient and remainder = dividend.
  always_comb begin
    wa_d     = wa_q;
    wb_d     = wb_q;
    acc_d    = acc_q;
    rem_sh   = {acc_q, wb_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, wa_q};
    if (iter_q == IT_MUL) begin
      acc_d = acc_q + (wb_q[0] ? wa_q : '0);
      wa_d  = wa_q << 1;
      wb_d  = wb_q >> 1;
    end else if (!rem_diff[XLEN]) begin
      acc_d = rem_diff[XLEN-1:0];
      wb_d  = {wb_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = rem_sh[XLEN-1:0];
      wb_d  = {wb_q[XLEN-2:0], 1'b0};
    end
    iter_res = (iter_q == IT_DIVU) ? wb_d : acc_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      iter_q  <= IT_MUL;
      cnt_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      acc_q   <= '0;
      peq_q   <= 1'b0;
      plt_q   <= 1'b0;
      pltu_q  <= 1'b0;
      c_q     <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (accept && is_iter) begin
        state_q <= BUSY;
        iter_q  <= iter_in;
        cnt_q   <= CNT_W'(XLEN);
        wa_q    <= (iter_in == IT_MUL) ? A_i : b_op;
        wb_q    <= (iter_in == IT_MUL) ? b_op : A_i;
        acc_q   <= '0;
        peq_q   <= eq_in;
        plt_q   <= lt_in;
        pltu_q  <= ltu_in;
        valid_q <= 1'b0;
      end else if (accept) begin
        c_q     <= alu_res;
        eq_q    <= eq_in;
        lt_q    <= lt_in;
        ltu_q   <= ltu_in;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready_i) begin
        valid_q <= 1'b0;
      end
    end else begin
      wa_q  <= wa_d;
      wb_q  <= wb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_iter) begin
        state_q <= IDLE;
        c_q     <= iter_res;
        eq_q    <= peq_q;
        lt_q    <= plt_q;
        ltu_q   <= pltu_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign C_o         = c_q;
  assign eq_o        = eq_q;
  assign lt_o        = lt_q;
  assign ltu_o       = ltu_q;

endmodule

// File: tb/tb_pipe_execute.sv
// Scoreboard bench for pipe_execute (XLEN=32): expected results are queued at
// accept time from a behavioural model and compared when the DUT hands them off.
module tb_pipe_execute;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        alub_sel_i;
  logic [5:0]  alu_op_i;
  logic [31:0] A_i, rD2_i, ext_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] C_o;
  logic        eq_o, lt_o, ltu_o;

  typedef struct {
    logic [34:0] val;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;

  pipe_execute #(.XLEN(32), .OP_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alub_sel_i(alub_sel_i), .alu_op_i(alu_op_i),
    .A_i(A_i), .rD2_i(rD2_i), .ext_i(ext_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .C_o(C_o), .eq_o(eq_o), .lt_o(lt_o), .ltu_o(ltu_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Result packed as {C, eq, lt, ltu}.
  function automatic logic [34:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] c;
    case (op)
      6'd0:    c = a + b;
      6'd1:    c = a - b;
      6'd2:    c = a & b;
      6'd3:    c = a | b;
      6'd4:    c = a ^ b;
      6'd5:    c = a << b[4:0];
      6'd6:    c = a >> b[4:0];
      6'd7:    c = $signed(a) >>> b[4:0];
      6'd8:    c = a * b;
      6'd9:    c = (b == 0) ? 32'hFFFF_FFFF : a / b;
      6'd10:   c = (b == 0) ? a : a % b;
      default: c = '0;
    endcase
    return {c, a == b, $signed(a) < $signed(b), a < b};
  endfunction

  // Entered and left just after a rising edge; holds the bundle until accepted.
  task automatic send(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic sel, input bit track);
    exp_t e;
    bit   done;
    done       = 1'b0;
    in_valid_i = 1'b1;
    alu_op_i   = op;
    A_i        = a;
    alub_sel_i = sel;
    if (sel) begin ext_i = b; rD2_i = $urandom; end
    else     begin rD2_i = b; ext_i = $urandom; end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (in_ready_o && !flush_i) begin
        done = 1'b1;
        if (track) begin
          e.val = model(op, a, b);
          e.tag = tag;
          sb_q.push_back(e);
        end
      end
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    if (!done) check({tag, "_ready"}, 64'(in_ready_o), 64'(1));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk_i);
    check(tag, 64'(sb_q.size()), 64'(0));
    @(posedge clk_i); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) check("spurious_result", 64'(out_valid_o), 64'(0));
        else begin
          e = sb_q.pop_front();
          check(e.tag, 64'({C_o, eq_o, lt_o, ltu_o}), 64'(e.val));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] b2b_ops [10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd12, 6'd63};
  logic [5:0] it_ops  [3]  = '{6'd8, 6'd9, 6'd10};

  initial begin : stim
    int c0;
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    alub_sel_i = 1'b0; alu_op_i = '0; A_i = '0; rD2_i = '0; ext_i = '0;

    repeat (2) @(negedge clk_i);
    check("rst_valid", 64'(out_valid_o), 64'(0));
    check("rst_c", 64'(C_o), 64'(0));
    check("rst_flags", 64'({eq_o, lt_o, ltu_o}), 64'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_rst", 64'(in_ready_o), 64'(1));
    @(posedge clk_i); #1;

    // Wrapping add, then single-cycle latency.
    send("add_wrap", 6'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    @(negedge clk_i);
    check("add_latency", 64'(out_valid_o), 64'(1));
    @(posedge clk_i); #1;
    send("sra_imm", 6'd7, 32'h8000_0000, 32'h24, 1'b1, 1'b1);

    // Back-to-back single-cycle ops must stream one per cycle.
    c0 = cyc;
    for (int i = 0; i < 10; i++)
      send($sformatf("b2b_op%0d", b2b_ops[i]), b2b_ops[i], $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'b1);
    check("b2b_cycles", 64'(cyc - c0), 64'(10));

    // Multiply latency: busy for XLEN cycles, result in cycle k+33.
    wait_drain("drain_pre_mul");
    send("mul", 6'd8, 32'h0001_0000, 32'h0001_0001, 1'b0, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk_i);
      check($sformatf("mul_busy_ready_%0d", i), 64'(in_ready_o), 64'(0));
      check($sformatf("mul_busy_valid_%0d", i), 64'(out_valid_o), 64'(0));
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("mul_done_valid", 64'(out_valid_o), 64'(1));
    @(posedge clk_i); #1;

    send("divu_by0", 6'd9, 32'd7, 32'd0, 1'b0, 1'b1);
    send("remu_by0", 6'd10, 32'd7, 32'd0, 1'b1, 1'b1);
    send("remu_100_7", 6'd10, 32'd100, 32'd7, 1'b0, 1'b1);
    send("divu_100_7", 6'd9, 32'd100, 32'd7, 1'b1, 1'b1);
    send("divu_big", 6'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      send($sformatf("rnd_it%0d", i), it_ops[i % 3], $urandom,
           (i < 3) ? $urandom : 32'($urandom_range(1, 300)), 1'b0, 1'b1);

    // Backpressure: result held, new bundle ignored until the result drains.
    wait_drain("drain_pre_bp");
    out_ready_i = 1'b0;
    send("bp_add", 6'd0, 32'd5, 32'd3, 1'b0, 1'b1);
    in_valid_i = 1'b1; alu_op_i = 6'd4; A_i = 32'd1; alub_sel_i = 1'b0; rD2_i = 32'd2;
    repeat (5) begin
      @(negedge clk_i);
      check("bp_hold_c", 64'(C_o), 64'(8));
      check("bp_hold_ready", 64'(in_ready_o), 64'(0));
      check("bp_hold_valid", 64'(out_valid_o), 64'(1));
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    send("bp_xor", 6'd4, 32'd1, 32'd2, 1'b0, 1'b1);

    // Flush mid-divide: result must never appear.
    wait_drain("drain_pre_flush");
    send("flush_div", 6'd9, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_ready", 64'(in_ready_o), 64'(1));
    for (int i = 0; i < 40; i++) begin
      check($sformatf("flush_novalid_%0d", i), 64'(out_valid_o), 64'(0));
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;

    // Flush blocks an accept in the same cycle.
    in_valid_i = 1'b1; alu_op_i = 6'd0; A_i = 32'd1; rD2_i = 32'd1; alub_sel_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_blocks_accept", 64'(out_valid_o), 64'(0));
    @(posedge clk_i); #1;

    // Asynchronous reset in the middle of a multiply.
    send("pre_rst_add", 6'd0, 32'd3, 32'd4, 1'b0, 1'b1);
    wait_drain("drain_pre_rst");
    send("rst_mul", 6'd8, 32'd12345, 32'd678, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk_i); #1; end
    #2 rst_i = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid_o), 64'(0));
    check("midrst_c", 64'(C_o), 64'(0));
    check("midrst_flags", 64'({eq_o, lt_o, ltu_o}), 64'(0));
    check("midrst_ready", 64'(in_ready_o), 64'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", 64'(in_ready_o), 64'(1));
    @(posedge clk_i); #1;
    send("post_rst_sub", 6'd1, 32'd2, 32'd9, 1'b1, 1'b1);
    send("post_rst_sll", 6'd5, 32'h0000_00F1, 32'h0000_0023, 1'b0, 1'b1);

    wait_drain("final_drain");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
